port_egress_rx: RTL and testbench

PORT_EGRESS_RX -- requirements
Module: port_egress_rx

---
 rtl/switch_pkg.sv | 24 ++
 rtl/rx_fifo.sv | 76 +++++++
 rtl/port_egress_rx.sv | 129 ++++++++++++
 tb/tb_port_egress_rx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : switch_pkg
// Description : Shared switch types: default widths, packet struct, counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
package switch_pkg;

    localparam int c_data_width = 16;
    localparam int c_addr_width = 4;

    // Field order matches the switch fabric's {data, target, source} concatenation.
    typedef struct packed {
        logic [c_data_width-1:0] data;
        logic [c_addr_width-1:0] target;
        logic [c_addr_width-1:0] source;
    } pkt_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rx_fifo
// Description : First-word-fall-through packet buffer of pkt_t entries.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_fifo
    import switch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  pkt_t i_push_pkt,
    input  logic i_pop,
    output pkt_t o_head_pkt,
    output logic o_full,
    output logic o_empty
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    pkt_t                mem_q [DEPTH];
    logic [c_ptr_w-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0]  count_q,  count_d;
    logic                w_do_push;
    logic                w_do_pop;

    assign o_full     = (count_q == c_cnt_w'(DEPTH));
    assign o_empty    = (count_q == '0);
    assign o_head_pkt = mem_q[rd_ptr_q];

    // A full buffer may still accept when the head leaves in the same cycle.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (w_do_push && !w_do_pop) begin
            count_d = count_q + 1'b1;
        end else if (w_do_pop && !w_do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !rst) begin
            mem_q[wr_ptr_q] <= i_push_pkt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/port_egress_rx.sv
`default_nettype none
// ============================================================================
// Module      : port_egress_rx
// Description : Switch egress receiver: optional target filter, packet buffer,
//               saturating packet/drop/misroute counters.
//               Macro RX_MISROUTE_CHECK_EN enables target filtering.
// Revision    : 1.0 - initial release
// ============================================================================
module port_egress_rx
    import switch_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width,
    parameter int ADDR_WIDTH = c_addr_width,
    parameter int PORT_ID    = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [ADDR_WIDTH-1:0] source_in,
    input  logic [ADDR_WIDTH-1:0] target_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH-1:0] rd_source,
    output logic [ADDR_WIDTH-1:0] rd_target,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [15:0]           pkt_count,
    output logic [15:0]           drop_count,
    output logic [15:0]           misroute_count
);

    pkt_t        w_push_pkt;
    pkt_t        w_head_pkt;
    logic        w_full;
    logic        w_empty;
    logic        w_accept;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    logic [15:0] pkt_count_q,  pkt_count_d;
    logic [15:0] drop_count_q, drop_count_d;

    always_comb begin
        w_push_pkt.data   = data_in;
        w_push_pkt.target = target_in;
        w_push_pkt.source = source_in;
    end

`ifdef RX_MISROUTE_CHECK_EN
    logic        w_misroute;
    logic [15:0] misroute_count_q, misroute_count_d;

    assign w_accept   = valid_in &  target_in[PORT_ID];
    assign w_misroute = valid_in & ~target_in[PORT_ID];

    always_comb begin
        misroute_count_d = misroute_count_q;
        if (w_misroute) begin
            misroute_count_d = sat_inc(misroute_count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misroute_count_q <= '0;
        end else begin
            misroute_count_q <= misroute_count_d;
        end
    end

    assign misroute_count = misroute_count_q;
`else
    assign w_accept       = valid_in;
    assign misroute_count = '0;
`endif

    assign w_pop  = ~w_empty & rd_ready;
    assign w_push = w_accept & (~w_full | w_pop);
    assign w_drop = w_accept & w_full & ~w_pop;

    always_comb begin
        pkt_count_d  = pkt_count_q;
        drop_count_d = drop_count_q;
        if (w_push) begin
            pkt_count_d = sat_inc(pkt_count_q);
        end
        if (w_drop) begin
            drop_count_d = sat_inc(drop_count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            pkt_count_q  <= pkt_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_pkt (w_push_pkt),
        .i_pop      (w_pop),
        .o_head_pkt (w_head_pkt),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // Stale storage is masked so the read port reads zero whenever nothing is held.
    assign rd_valid       = ~w_empty;
    assign rd_source      = w_empty ? '0 : w_head_pkt.source;
    assign rd_target      = w_empty ? '0 : w_head_pkt.target;
    assign rd_data        = w_empty ? '0 : w_head_pkt.data;
    assign full           = w_full;
    assign empty          = w_empty;
    assign pkt_count      = pkt_count_q;
    assign drop_count     = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_port_egress_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_port_egress_rx
// Description : Self-checking bench for port_egress_rx (directed table + random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_port_egress_rx;

    localparam int DEPTH = 4;
`ifdef RX_MISROUTE_CHECK_EN
    localparam bit FILTER = 1'b1;
    localparam int PB     = 6;
`else
    localparam bit FILTER = 1'b0;
    localparam int PB     = 7;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [3:0]  source_in = '0;
    logic [3:0]  target_in = '0;
    logic [15:0] data_in = '0;
    logic        rd_ready = 1'b0;
    logic        rd_valid;
    logic [3:0]  rd_source;
    logic [3:0]  rd_target;
    logic [15:0] rd_data;
    logic        full;
    logic        empty;
    logic [15:0] pkt_count;
    logic [15:0] drop_count;
    logic [15:0] misroute_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    port_egress_rx dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .source_in      (source_in),
        .target_in      (target_in),
        .data_in        (data_in),
        .rd_ready       (rd_ready),
        .rd_valid       (rd_valid),
        .rd_source      (rd_source),
        .rd_target      (rd_target),
        .rd_data        (rd_data),
        .full           (full),
        .empty          (empty),
        .pkt_count      (pkt_count),
        .drop_count     (drop_count),
        .misroute_count (misroute_count)
    );

    // Reference model: an ordered list of packets plus plain integer counters.
    logic [23:0] m_q [$];
    int          m_pkt, m_drop, m_mis;

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic v, input logic [3:0] s,
                              input logic [3:0] t, input logic [15:0] d, input logic rdy);
        bit acc;
        if (r) begin
            m_q.delete();
            m_pkt = 0; m_drop = 0; m_mis = 0;
            return;
        end
        acc = v && (!FILTER || t[0]);
        if (FILTER && v && !t[0]) m_mis = sat(m_mis);
        if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
        if (acc) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back({d, t, s});
                m_pkt = sat(m_pkt);
            end else begin
                m_drop = sat(m_drop);
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [23:0] head;
        head = (m_q.size() > 0) ? m_q[0] : 24'h0;
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(m_q.size() > 0));
        chk({tag, ".rd_data"},  32'(rd_data),  32'(head[23:8]));
        chk({tag, ".rd_tgt"},   32'(rd_target), 32'(head[7:4]));
        chk({tag, ".rd_src"},   32'(rd_source), 32'(head[3:0]));
        chk({tag, ".full"},     32'(full),  32'(m_q.size() == DEPTH));
        chk({tag, ".empty"},    32'(empty), 32'(m_q.size() == 0));
        chk({tag, ".pkt"},      32'(pkt_count),      32'(m_pkt));
        chk({tag, ".drop"},     32'(drop_count),     32'(m_drop));
        chk({tag, ".mis"},      32'(misroute_count), 32'(m_mis));
    endtask

    task automatic step(input string tag, input logic r, input logic v, input logic [3:0] s,
                        input logic [3:0] t, input logic [15:0] d, input logic rdy);
        @(negedge clk);
        rst = r; valid_in = v; source_in = s; target_in = t; data_in = d; rd_ready = rdy;
        @(posedge clk);
        model_edge(r, v, s, t, d, rdy);
        #1;
        check_model(tag);
    endtask

    typedef struct {
        logic        r, v;
        logic [3:0]  s, t;
        logic [15:0] d;
        logic        rdy;
        logic        e_vld;
        logic [15:0] e_data;
        logic        e_full;
        int          e_pkt, e_drop, e_mis;
    } vec_t;

    vec_t vt [20];

    initial begin
        int mis1;
        mis1 = FILTER ? 1 : 0;
        //         r  v  src     tgt     data      rdy  vld data     full pkt    drop mis
        vt[0]  = '{1, 0, 4'h0,   4'h0,   16'h0000, 0,   0, 16'h0000, 0,   0,     0,   0};
        vt[1]  = '{0, 1, 4'b0010,4'b0001,16'hA5A5, 0,   1, 16'hA5A5, 0,   1,     0,   0};
        vt[2]  = '{0, 0, 4'h0,   4'h0,   16'h0000, 1,   0, 16'h0000, 0,   1,     0,   0};
        vt[3]  = '{0, 1, 4'h2,   4'h1,   16'h0001, 0,   1, 16'h0001, 0,   2,     0,   0};
        vt[4]  = '{0, 1, 4'h2,   4'h1,   16'h0002, 0,   1, 16'h0001, 0,   3,     0,   0};
        vt[5]  = '{0, 1, 4'h2,   4'h1,   16'h0003, 0,   1, 16'h0001, 0,   4,     0,   0};
        vt[6]  = '{0, 1, 4'h2,   4'h1,   16'h0004, 0,   1, 16'h0001, 1,   5,     0,   0};
        vt[7]  = '{0, 1, 4'h2,   4'h1,   16'h0005, 0,   1, 16'h0001, 1,   5,     1,   0};
        vt[8]  = '{0, 1, 4'h2,   4'h1,   16'h0006, 1,   1, 16'h0002, 1,   6,     1,   0};
        vt[9]  = '{0, 0, 4'h0,   4'h0,   16'h0000, 1,   1, 16'h0003, 0,   6,     1,   0};
        vt[10] = '{0, 0, 4'h0,   4'h0,   16'h0000, 1,   1, 16'h0004, 0,   6,     1,   0};
        vt[11] = '{0, 0, 4'h0,   4'h0,   16'h0000, 1,   1, 16'h0006, 0,   6,     1,   0};
        vt[12] = '{0, 0, 4'h0,   4'h0,   16'h0000, 1,   0, 16'h0000, 0,   6,     1,   0};
        vt[13] = '{0, 1, 4'h2,   4'b0100,16'h0BAD, 0, !FILTER, FILTER ? 16'h0 : 16'h0BAD, 0, PB, 1, mis1};
        vt[14] = '{0, 0, 4'h0,   4'h0,   16'h0000, 1,   0, 16'h0000, 0,   PB,    1,   mis1};
        vt[15] = '{0, 1, 4'h4,   4'h1,   16'h0011, 0,   1, 16'h0011, 0,   PB+1,  1,   mis1};
        vt[16] = '{0, 1, 4'h4,   4'h1,   16'h0012, 0,   1, 16'h0011, 0,   PB+2,  1,   mis1};
        vt[17] = '{0, 1, 4'h4,   4'h1,   16'h0013, 0,   1, 16'h0011, 0,   PB+3,  1,   mis1};
        vt[18] = '{1, 1, 4'h4,   4'h1,   16'h0099, 0,   0, 16'h0000, 0,   0,     0,   0};
        vt[19] = '{0, 0, 4'h0,   4'h0,   16'h0000, 0,   0, 16'h0000, 0,   0,     0,   0};

        for (int i = 0; i < 20; i++) begin
            step($sformatf("vec%0d", i), vt[i].r, vt[i].v, vt[i].s, vt[i].t, vt[i].d, vt[i].rdy);
            chk($sformatf("vec%0d.tbl_vld", i),  32'(rd_valid),       32'(vt[i].e_vld));
            chk($sformatf("vec%0d.tbl_data", i), 32'(rd_data),        32'(vt[i].e_data));
            chk($sformatf("vec%0d.tbl_full", i), 32'(full),           32'(vt[i].e_full));
            chk($sformatf("vec%0d.tbl_pkt", i),  32'(pkt_count),      32'(vt[i].e_pkt));
            chk($sformatf("vec%0d.tbl_drop", i), 32'(drop_count),     32'(vt[i].e_drop));
            chk($sformatf("vec%0d.tbl_mis", i),  32'(misroute_count), 32'(vt[i].e_mis));
        end

        // Random traffic with occasional mid-stream resets.
        for (int i = 0; i < 600; i++) begin
            logic [3:0] t;
            t = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) t[0] = 1'b1;
            step($sformatf("rnd%0d", i), ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)), t,
                 16'($urandom), ($urandom_range(0, 2) == 0));
        end

        // Drop counter saturation: preload near the top, then overflow a full buffer.
        step("sat_rst", 1, 0, 4'h0, 4'h0, 16'h0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            step($sformatf("sat_fill%0d", i), 0, 1, 4'h1, 4'h1, 16'(16'h100 + i), 0);
        end
        @(negedge clk);
        valid_in = 1'b0; rd_ready = 1'b0;
        force dut.drop_count_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.drop_count_q;
        m_drop = 16'hFFFE;
        chk("sat_preload", 32'(drop_count), 32'hFFFE);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("sat_drop%0d", i), 0, 1, 4'h1, 4'h1, 16'hDEAD, 0);
        end
        chk("drop_saturated", 32'(drop_count), 32'hFFFF);
        chk("sat_head_kept", 32'(rd_data), 32'h0100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
